frame_ram_scheduler: RTL and testbench
======================================

FRAME_RAM_SCHEDULER -- requirements
Module: frame_ram_scheduler

Interface
REQ-001 SHALL have parameter width_p, default 4, pixel data width in bits.
REQ-002 SHALL have parameter depth_p, default 19200, frame RAM depth in pixels (160x120).
REQ-003 SHALL have parameter conv_pixels_p, default 18644, number of Sobel results per pass (158x118).
REQ-004 SHALL derive addr_w = $clog2(depth_p), the width of every address port.
REQ-005 SHALL have clk_i, input, 1, the single clock for all state.
REQ-006 SHALL have reset_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have start_i, input, 1, request to begin a Sobel pass.
REQ-008 SHALL have sep_rd_addr_i, input, addr_w, read address from the 3x3 separator.
REQ-009 SHALL have disp_rd_addr_i, input, addr_w, read address from the display scaler.
REQ-010 SHALL have sobel_valid_i, input, 1, Sobel core result valid.
REQ-011 SHALL have sobel_data_i, input, width_p, Sobel core result.
REQ-012 SHALL have frame_i, input, 1, single-cycle display frame-start pulse.
REQ-013 SHALL have rd_addr_o, output, addr_w, RAM read address.
REQ-014 SHALL have wr_en_o / wr_addr_o / wr_data_o, outputs, 1 / addr_w / width_p, RAM write port.
REQ-015 SHALL have sep_en_o, output, 1, enable to separator (reads permitted).
REQ-016 SHALL have disp_sel_o, output, 1, display owns the read port and RAM data is paintable.
REQ-017 SHALL have done_o, output, 1, single-cycle pulse when the last Sobel write is accepted.
REQ-018 SHALL have err_o, output, 1, sticky flag for a write attempted outside RUN.

Function
REQ-019 SHALL implement states IDLE, RUN, WAIT_FRAME and DISPLAY in a registered FSM.
REQ-020 SHALL move IDLE->RUN on start_i=1 and clear the write counter to 0 on that edge.
REQ-021 SHALL in RUN drive sep_en_o=1, rd_addr_o=sep_rd_addr_i (combinational) and wr_en_o=sobel_valid_i.
REQ-022 SHALL drive wr_addr_o = write counter and wr_data_o = sobel_data_i, combinationally.
REQ-023 SHALL increment the write counter by 1 on each cycle with wr_en_o=1; it never wraps within a pass.
REQ-024 SHALL, when wr_en_o=1 and counter = conv_pixels_p-1, go to WAIT_FRAME and pulse done_o on the next cycle for exactly 1 cycle.
REQ-025 SHALL in WAIT_FRAME hold sep_en_o=0, disp_sel_o=0, wr_en_o=0 and rd_addr_o=0.
REQ-026 SHALL move WAIT_FRAME->DISPLAY on frame_i=1, so ownership changes only at a frame boundary.
REQ-027 SHALL in DISPLAY drive disp_sel_o=1, rd_addr_o=disp_rd_addr_i and sep_en_o=0.
REQ-028 SHALL treat start_i in DISPLAY as a restart: go to RUN with the counter cleared and disp_sel_o=0 from the next cycle.
REQ-029 SHALL ignore start_i in RUN and WAIT_FRAME.
REQ-030 SHALL force wr_en_o=0 outside RUN, and set err_o if sobel_valid_i=1 outside RUN.
REQ-031 SHALL evaluate both transitions if start_i and frame_i are high together in WAIT_FRAME, with frame_i winning (go to DISPLAY).
REQ-032 SHALL let a write with wr_en_o=1 on the final count complete before leaving RUN; no write is dropped or duplicated.

Reset
REQ-033 SHALL on reset_i=1, immediately and asynchronously, set the state to IDLE, counter=0, done_o=0, err_o=0.
REQ-034 SHALL in IDLE drive sep_en_o=0, disp_sel_o=0, wr_en_o=0, rd_addr_o=0 and wr_addr_o=0.
REQ-035 SHALL on reset mid-RUN abandon the pass; a new start_i restarts from address 0.

Verification
REQ-036 SHALL cover: reset, start_i pulse, conv_pixels_p valid beats -> wr_addr_o goes 0..18643, done_o pulses once, state is WAIT_FRAME.
REQ-037 SHALL cover: in WAIT_FRAME, frame_i after 100 cycles -> disp_sel_o=1 on the next cycle and rd_addr_o tracks disp_rd_addr_i.
REQ-038 SHALL cover: sobel_valid_i=1 in DISPLAY -> wr_en_o=0 and err_o=1 until reset.
REQ-039 SHALL cover: start_i in DISPLAY -> RUN, first write at wr_addr_o=0, disp_sel_o=0.
REQ-040 SHALL cover: reset_i asserted mid-RUN at count 500 -> all outputs return to IDLE values in the same cycle, without waiting for a clock edge.
REQ-041 SHALL cover: start_i and frame_i high together in WAIT_FRAME -> state is DISPLAY.

Source files
------------

// File: rtl/frame_ram_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_ram_scheduler: shares one frame RAM between a Sobel pass (writes)
// and the display scaler (reads), handing ownership over at frame starts.
// Rev 1.0
// ----------------------------------------------------------------------------
module frame_ram_scheduler #(
  parameter int width_p       = 4,
  parameter int depth_p       = 19200,
  parameter int conv_pixels_p = 18644,
  localparam int addr_w       = $clog2(depth_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [addr_w-1:0]   sep_rd_addr_i,
  input  logic [addr_w-1:0]   disp_rd_addr_i,
  input  logic                sobel_valid_i,
  input  logic [width_p-1:0]  sobel_data_i,
  input  logic                frame_i,
  output logic [addr_w-1:0]   rd_addr_o,
  output logic                wr_en_o,
  output logic [addr_w-1:0]   wr_addr_o,
  output logic [width_p-1:0]  wr_data_o,
  output logic                sep_en_o,
  output logic                disp_sel_o,
  output logic                done_o,
  output logic                err_o
);

  localparam logic [addr_w-1:0] c_last_cnt = addr_w'(conv_pixels_p - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RUN        = 2'd1,
    S_WAIT_FRAME = 2'd2,
    S_DISPLAY    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [addr_w-1:0]   r_cnt;
  logic [addr_w-1:0]   w_cnt_nxt;
  logic                r_done;
  logic                r_err;
  logic                w_last_wr;
  logic                w_sep_en;
  logic                w_disp_sel;
  logic                w_wr_en;
  logic [addr_w-1:0]   w_rd_addr;
  logic                w_bad_wr;

  // Any Sobel result arriving while the pass is not running is a protocol error.
  assign w_bad_wr = sobel_valid_i && (r_state != S_RUN);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_last_wr;
      r_err   <= r_err | w_bad_wr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_wr   = 1'b0;
    w_sep_en    = 1'b0;
    w_disp_sel  = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_addr   = '0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        w_sep_en  = 1'b1;
        w_rd_addr = sep_rd_addr_i;
        w_wr_en   = sobel_valid_i;
        if (sobel_valid_i) begin
          // The final write is issued this cycle; leave RUN only afterwards.
          w_cnt_nxt = r_cnt + addr_w'(1);
          if (r_cnt == c_last_cnt) begin
            w_last_wr   = 1'b1;
            w_state_nxt = S_WAIT_FRAME;
          end
        end
      end
      S_WAIT_FRAME: begin
        if (frame_i) begin
          w_state_nxt = S_DISPLAY;
        end
      end
      S_DISPLAY: begin
        w_disp_sel = 1'b1;
        w_rd_addr  = disp_rd_addr_i;
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign rd_addr_o  = w_rd_addr;
  assign wr_en_o    = w_wr_en;
  assign wr_addr_o  = r_cnt;
  assign wr_data_o  = sobel_data_i;
  assign sep_en_o   = w_sep_en;
  assign disp_sel_o = w_disp_sel;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_ram_scheduler.sv
`default_nettype none
// Testbench for frame_ram_scheduler: scoreboard of expected RAM writes plus
// per-scenario ownership and flag checks.
module tb_frame_ram_scheduler;

  localparam int W     = 4;
  localparam int DEPTH = 19200;
  localparam int CONV  = 18644;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] sep_rd_addr_i = '0;
  logic [AW-1:0] disp_rd_addr_i = '0;
  logic          sobel_valid_i = 1'b0;
  logic [W-1:0]  sobel_data_i = '0;
  logic          frame_i = 1'b0;
  logic [AW-1:0] rd_addr_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [W-1:0]  wr_data_o;
  logic          sep_en_o;
  logic          disp_sel_o;
  logic          done_o;
  logic          err_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int m_cnt = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [W-1:0]  exp_data_q[$];

  frame_ram_scheduler #(
    .width_p(W), .depth_p(DEPTH), .conv_pixels_p(CONV)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .sep_rd_addr_i(sep_rd_addr_i), .disp_rd_addr_i(disp_rd_addr_i),
    .sobel_valid_i(sobel_valid_i), .sobel_data_i(sobel_data_i),
    .frame_i(frame_i), .rd_addr_o(rd_addr_o), .wr_en_o(wr_en_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .sep_en_o(sep_en_o),
    .disp_sel_o(disp_sel_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (done_o === 1'b1) n_done++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (sep_en_o !== 1'b1 || disp_sel_o !== 1'b0) begin
      n_err++;
      $display("FAIL start_to_run: sep_en=%b disp_sel=%b want 1/0", sep_en_o, disp_sel_o);
    end
  endtask

  // Drives n valid beats (optional gaps), checking every cycle against the queue.
  task automatic drive_beats(input int n, input bit gaps, input int poke_start);
    int sent = 0;
    int cyc = 0;
    logic [AW-1:0] ea;
    logic [W-1:0]  ed;
    while (sent < n && cyc < 2 * n + 100) begin
      @(posedge clk_i); #1;
      sobel_valid_i = !(gaps && ($urandom_range(0, 7) == 0));
      sobel_data_i  = W'($urandom);
      sep_rd_addr_i = AW'($urandom_range(0, DEPTH - 1));
      start_i       = (sent == poke_start) && sobel_valid_i;
      if (sobel_valid_i) begin
        exp_addr_q.push_back(AW'(m_cnt));
        exp_data_q.push_back(sobel_data_i);
        m_cnt++;
        sent++;
      end
      @(negedge clk_i);
      n_cmp++;
      if (wr_en_o !== sobel_valid_i) begin
        n_err++;
        $display("FAIL wr_en: got %b want %b (beat %0d)", wr_en_o, sobel_valid_i, sent);
      end
      n_cmp++;
      if (rd_addr_o !== sep_rd_addr_i || sep_en_o !== 1'b1) begin
        n_err++;
        $display("FAIL run_rd: rd_addr=%0d sep_en=%b want %0d/1", rd_addr_o, sep_en_o, sep_rd_addr_i);
      end
      n_cmp++;
      if (done_o !== 1'b0) begin
        n_err++;
        $display("FAIL early_done: got %b want 0 (beat %0d)", done_o, sent);
      end
      if (sobel_valid_i && exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        n_cmp++;
        if (wr_addr_o !== ea || wr_data_o !== ed) begin
          n_err++;
          $display("FAIL write: addr=%0d data=%0h want addr=%0d data=%0h", wr_addr_o, wr_data_o, ea, ed);
        end
      end
      cyc++;
    end
    n_cmp++;
    if (sent != n) begin
      n_err++;
      $display("FAIL beat_budget: sent %0d want %0d", sent, n);
    end
    @(posedge clk_i); #1;
    sobel_valid_i = 1'b0;
    start_i       = 1'b0;
  endtask

  task automatic check_pass_end(input int want_done);
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_pulse: got %b want 1", done_o);
    end
    n_cmp++;
    if (sep_en_o !== 1'b0 || disp_sel_o !== 1'b0 || wr_en_o !== 1'b0 || rd_addr_o !== '0) begin
      n_err++;
      $display("FAIL wait_outputs: sep=%b disp=%b wr_en=%b rd=%0d want 0/0/0/0",
               sep_en_o, disp_sel_o, wr_en_o, rd_addr_o);
    end
    n_cmp++;
    if (exp_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL lost_writes: %0d pending want 0", exp_addr_q.size());
    end
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b0 || n_done != want_done) begin
      n_err++;
      $display("FAIL done_once: done=%b pulses=%0d want 0/%0d", done_o, n_done, want_done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (sep_en_o !== 1'b0 || disp_sel_o !== 1'b0 || wr_en_o !== 1'b0 ||
        rd_addr_o !== '0 || wr_addr_o !== '0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: sep=%b disp=%b wr_en=%b rd=%0d wa=%0d done=%b err=%b want all 0",
               sep_en_o, disp_sel_o, wr_en_o, rd_addr_o, wr_addr_o, done_o, err_o);
    end
    @(posedge clk_i); #1 reset_i = 1'b0;
  endtask

  task automatic test_full_pass();
    m_cnt = 0;
    pulse_start();
    drive_beats(CONV, 1'b1, 100);
    check_pass_end(1);
  endtask

  task automatic test_wait_frame();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (sep_en_o !== 1'b0 || disp_sel_o !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_wait: sep=%b disp=%b want 0/0", sep_en_o, disp_sel_o);
    end
    repeat (100) @(posedge clk_i);
    #1 frame_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (disp_sel_o !== 1'b0) begin
      n_err++;
      $display("FAIL disp_early: got %b want 0", disp_sel_o);
    end
    @(posedge clk_i); #1 frame_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp_rd_addr_i = AW'($urandom_range(0, DEPTH - 1));
      sep_rd_addr_i  = AW'($urandom_range(0, DEPTH - 1));
      @(negedge clk_i);
      n_cmp++;
      if (disp_sel_o !== 1'b1 || rd_addr_o !== disp_rd_addr_i || sep_en_o !== 1'b0 || err_o !== 1'b0) begin
        n_err++;
        $display("FAIL display: disp=%b rd=%0d sep=%b err=%b want 1/%0d/0/0",
                 disp_sel_o, rd_addr_o, sep_en_o, err_o, disp_rd_addr_i);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_err_in_display();
    sobel_valid_i = 1'b1;
    sobel_data_i  = W'($urandom);
    @(negedge clk_i);
    n_cmp++;
    if (wr_en_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL display_write: wr_en=%b err=%b want 0/0", wr_en_o, err_o);
    end
    @(posedge clk_i); #1 sobel_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (err_o !== 1'b1 || disp_sel_o !== 1'b1) begin
        n_err++;
        $display("FAIL err_sticky: err=%b disp=%b want 1/1", err_o, disp_sel_o);
      end
    end
  endtask

  task automatic test_restart_and_async_reset();
    m_cnt = 0;
    pulse_start();
    drive_beats(500, 1'b0, -1);
    sobel_valid_i = 1'b1;
    sep_rd_addr_i = AW'(1234);
    #1;
    n_cmp++;
    if (wr_addr_o !== AW'(m_cnt) || wr_en_o !== 1'b1 || rd_addr_o !== AW'(1234)) begin
      n_err++;
      $display("FAIL mid_run: wa=%0d wr_en=%b rd=%0d want %0d/1/1234", wr_addr_o, wr_en_o, rd_addr_o, m_cnt);
    end
    reset_i = 1'b1;
    #1;
    n_cmp++;
    if (sep_en_o !== 1'b0 || disp_sel_o !== 1'b0 || wr_en_o !== 1'b0 || rd_addr_o !== '0 ||
        wr_addr_o !== '0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: sep=%b disp=%b wr_en=%b rd=%0d wa=%0d done=%b err=%b want all 0",
               sep_en_o, disp_sel_o, wr_en_o, rd_addr_o, wr_addr_o, done_o, err_o);
    end
    sobel_valid_i = 1'b0;
    @(posedge clk_i); #1 reset_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    m_cnt = 0;
    pulse_start();
    drive_beats(CONV, 1'b0, -1);
    check_pass_end(2);
  endtask

  task automatic test_start_frame_together();
    @(posedge clk_i); #1 start_i = 1'b1; frame_i = 1'b1;
    disp_rd_addr_i = AW'(777);
    @(posedge clk_i); #1 start_i = 1'b0; frame_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (disp_sel_o !== 1'b1 || sep_en_o !== 1'b0 || rd_addr_o !== AW'(777)) begin
      n_err++;
      $display("FAIL start_frame_tie: disp=%b sep=%b rd=%0d want 1/0/777", disp_sel_o, sep_en_o, rd_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_wait_frame();
    test_err_in_display();
    test_restart_and_async_reset();
    test_back_to_back();
    test_start_frame_together();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
